// File: rtl/shiftadd_pkg.sv
// Shared definitions for the shift-add modular reduction slice: data widths,
// the operand-stage state encoding and the modulus class record consumed by
// the operand stage, the reducer and the eventual top level.
package shiftadd_pkg;

    localparam int unsigned OPERAND_WIDTH = 32;
    localparam int unsigned DATA_LENGTH   = 64;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef struct packed {
        logic is_mersenne;
        logic is_fermat;
        logic invalid;
    } mod_class_t;

endpackage

// File: rtl/shiftadd_mod_classify.sv
// Combinational modulus classifier.
// Ports:
//   m_i     - modulus, zero-extended to DATA_LENGTH
//   m_bl_i  - bit length of m_i (MSB index + 1, 0 for m_i == 0)
//   class_o - {is_mersenne, is_fermat, invalid}
module shiftadd_mod_classify
    import shiftadd_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = shiftadd_pkg::DATA_LENGTH
) (
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output mod_class_t             class_o
);

    localparam logic [DATA_LENGTH-1:0] ONE = {{(DATA_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_LENGTH-1:0] TWO = {{(DATA_LENGTH-2){1'b0}}, 2'b10};

    logic invalid;
    logic wide_enough;
    logic mers_raw;
    logic ferm_raw;

    always_comb begin
        invalid     = (m_i < TWO);
        wide_enough = (m_bl_i >= TWO);
        mers_raw    = (m_i == ((ONE << m_bl_i) - ONE));
        ferm_raw    = (m_i == ((ONE << (m_bl_i - ONE)) + ONE));

        class_o             = '0;
        class_o.invalid     = invalid;
        class_o.is_mersenne = !invalid && wide_enough && mers_raw;
        // m == 3 satisfies both equations; it is reported as Mersenne only.
        class_o.is_fermat   = !invalid && wide_enough && ferm_raw && !mers_raw;
    end

endmodule

// File: rtl/shiftadd_operand_stage.sv
// Operand front end for the shift-add reducer. Accepts (a, b, m) over a
// valid/ready handshake, forms x = a*b with a one-bit-per-cycle shift-add
// multiplier, measures the bit length of m and classifies it in the same
// fixed OPERAND_WIDTH cycles, then holds the reducer-facing result behind an
// output valid/ready handshake.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   in_valid_i / in_ready_o   - operand request handshake
//   a_i, b_i, m_i             - multiplicand, multiplier, modulus
//   out_valid_o / out_ready_i - result handshake
//   x_o, m_o, m_bl_o          - product, modulus, modulus bit length
//   is_mersenne_o, is_fermat_o, mod_invalid_o - modulus class flags
module shiftadd_operand_stage
    import shiftadd_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = shiftadd_pkg::OPERAND_WIDTH,
    parameter int unsigned DATA_LENGTH   = shiftadd_pkg::DATA_LENGTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [OPERAND_WIDTH-1:0] a_i,
    input  logic [OPERAND_WIDTH-1:0] b_i,
    input  logic [OPERAND_WIDTH-1:0] m_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_LENGTH-1:0]   x_o,
    output logic [DATA_LENGTH-1:0]   m_o,
    output logic [DATA_LENGTH-1:0]   m_bl_o,
    output logic                     is_mersenne_o,
    output logic                     is_fermat_o,
    output logic                     mod_invalid_o
);

    localparam int unsigned CNT_W = $clog2(OPERAND_WIDTH);
    localparam int unsigned BL_W  = $clog2(OPERAND_WIDTH + 1);
    localparam int unsigned PAD_W = DATA_LENGTH - OPERAND_WIDTH;

    state_t                   state_q, state_d;
    logic [OPERAND_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_WIDTH-1:0] mplr_q, mplr_d;
    logic [OPERAND_WIDTH-1:0] scan_q, scan_d;
    logic [OPERAND_WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BL_W-1:0]          bl_q, bl_d;
    logic [DATA_LENGTH-1:0]   acc_q, acc_d;
    logic [DATA_LENGTH-1:0]   x_q, x_d;
    logic [DATA_LENGTH-1:0]   m_out_q, m_out_d;
    logic [DATA_LENGTH-1:0]   m_bl_q, m_bl_d;
    mod_class_t               class_q, class_d;

    logic [DATA_LENGTH-1:0]   a_ext;
    logic [DATA_LENGTH-1:0]   acc_next;
    logic [BL_W-1:0]          bl_next;
    logic [DATA_LENGTH-1:0]   m_ext;
    logic [DATA_LENGTH-1:0]   bl_ext;
    mod_class_t               class_next;

    // Classification sees the bit length including this cycle's scan step,
    // so the value captured on the final MUL cycle is complete.
    shiftadd_mod_classify #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_classify (
        .m_i     (m_ext),
        .m_bl_i  (bl_ext),
        .class_o (class_next)
    );

    always_comb begin
        a_ext    = {{PAD_W{1'b0}}, a_q};
        acc_next = mplr_q[0] ? (acc_q + (a_ext << cnt_q)) : acc_q;
        bl_next  = (scan_q != '0) ? (bl_q + BL_W'(1)) : bl_q;
        m_ext    = {{PAD_W{1'b0}}, m_q};
        bl_ext   = {{(DATA_LENGTH-BL_W){1'b0}}, bl_next};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mplr_d  = mplr_q;
        scan_d  = scan_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        bl_d    = bl_q;
        acc_d   = acc_q;
        x_d     = x_q;
        m_out_d = m_out_q;
        m_bl_d  = m_bl_q;
        class_d = class_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    mplr_d  = b_i;
                    scan_d  = m_i;
                    m_d     = m_i;
                    cnt_d   = '0;
                    bl_d    = '0;
                    acc_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_next;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                bl_d   = bl_next;
                if (scan_q != '0) begin
                    scan_d = scan_q >> 1;
                end
                if (cnt_q == CNT_W'(OPERAND_WIDTH - 1)) begin
                    x_d     = acc_next;
                    m_out_d = m_ext;
                    m_bl_d  = bl_ext;
                    class_d = class_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            mplr_q  <= '0;
            scan_q  <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            bl_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            m_out_q <= '0;
            m_bl_q  <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mplr_q  <= mplr_d;
            scan_q  <= scan_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            bl_q    <= bl_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            m_out_q <= m_out_d;
            m_bl_q  <= m_bl_d;
            class_q <= class_d;
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready_o    = (state_q == IDLE);
    assign out_valid_o   = (state_q == DONE);
    assign x_o           = x_q;
    assign m_o           = m_out_q;
    assign m_bl_o        = m_bl_q;
    assign is_mersenne_o = class_q.is_mersenne;
    assign is_fermat_o   = class_q.is_fermat;
    assign mod_invalid_o = class_q.invalid;

endmodule

// File: tb/tb_shiftadd_operand_stage.sv
module tb_shiftadd_operand_stage;

    localparam int OW = 32;
    localparam int DL = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [OW-1:0] m;
    logic          out_valid;
    logic          out_ready;
    logic [DL-1:0] x_o;
    logic [DL-1:0] m_o;
    logic [DL-1:0] m_bl_o;
    logic          is_mersenne;
    logic          is_fermat;
    logic          mod_invalid;

    int n_checks = 0;
    int n_pass   = 0;

    shiftadd_operand_stage #(
        .OPERAND_WIDTH (OW),
        .DATA_LENGTH   (DL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .a_i           (a),
        .b_i           (b),
        .m_i           (m),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .x_o           (x_o),
        .m_o           (m_o),
        .m_bl_o        (m_bl_o),
        .is_mersenne_o (is_mersenne),
        .is_fermat_o   (is_fermat),
        .mod_invalid_o (mod_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Presents a request on a falling edge and waits (bounded) for out_valid.
    // lat counts rising edges from the handshake edge to out_valid visible.
    task automatic send(input logic [OW-1:0] ai, input logic [OW-1:0] bi,
                        input logic [OW-1:0] mi, output int lat);
        @(negedge clk);
        chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
        a = ai; b = bi; m = mi; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic expect_res(input string tag, input int lat,
                              input logic [63:0] ex, input logic [63:0] em,
                              input logic [63:0] ebl, input logic eme,
                              input logic efe, input logic einv);
        chk({tag, ".latency"}, 64'(lat), 64'(OW + 1));
        chk({tag, ".x"}, x_o, ex);
        chk({tag, ".m"}, m_o, em);
        chk({tag, ".m_bl"}, m_bl_o, ebl);
        chk({tag, ".flags"}, {61'd0, is_mersenne, is_fermat, mod_invalid},
            {61'd0, eme, efe, einv});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        logic seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst.x", x_o, 64'd0);
        chk("rst.m", m_o, 64'd0);
        chk("rst.m_bl", m_bl_o, 64'd0);
        chk("rst.flags", {61'd0, is_mersenne, is_fermat, mod_invalid}, 64'd0);
        rst = 1'b0;

        send(32'd5, 32'd7, 32'd8191, lat);
        expect_res("mers8191", lat, 64'd35, 64'd8191, 64'd13, 1'b1, 1'b0, 1'b0);
        release_out("mers8191");

        send(32'd200, 32'd100, 32'd257, lat);
        expect_res("ferm257", lat, 64'd20000, 64'd257, 64'd9, 1'b0, 1'b1, 1'b0);
        release_out("ferm257");

        send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, lat);
        expect_res("maxops", lat, 64'hFFFFFFFE00000001, 64'hFFFFFFFB, 64'd32,
                   1'b0, 1'b0, 1'b0);
        release_out("maxops");

        send(32'd2, 32'd3, 32'd0, lat);
        expect_res("m0", lat, 64'd6, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        release_out("m0");

        send(32'd0, 32'd9, 32'd1, lat);
        expect_res("m1", lat, 64'd0, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
        release_out("m1");

        send(32'd11, 32'd13, 32'd3, lat);
        expect_res("m3", lat, 64'd143, 64'd3, 64'd2, 1'b1, 1'b0, 1'b0);
        release_out("m3");

        // Back-pressure: hold the result while a competing request is offered.
        send(32'd9, 32'd9, 32'd31, lat);
        expect_res("bp", lat, 64'd81, 64'd31, 64'd5, 1'b1, 1'b0, 1'b0);
        a = 32'd1; b = 32'd1; m = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp.hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp.hold_ready", {63'd0, in_ready}, 64'd0);
            chk("bp.hold_x", x_o, 64'd81);
            chk("bp.hold_bl", m_bl_o, 64'd5);
            chk("bp.hold_flags", {61'd0, is_mersenne, is_fermat, mod_invalid},
                64'd4);
        end
        in_valid = 1'b0;
        release_out("bp");

        send(32'd6, 32'd7, 32'd17, lat);
        expect_res("after_bp", lat, 64'd42, 64'd17, 64'd5, 1'b0, 1'b1, 1'b0);
        release_out("after_bp");

        // Reset while the multiplier is part way through.
        @(negedge clk);
        a = 32'd1000; b = 32'd1000; m = 32'd127; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst.x", x_o, 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst.no_partial", {63'd0, seen_valid}, 64'd0);

        send(32'd3, 32'd4, 32'd7, lat);
        expect_res("post_rst", lat, 64'd12, 64'd7, 64'd3, 1'b1, 1'b0, 1'b0);
        release_out("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
